velocity_resolver: RTL and testbench

- Responder end of the plane-state velocity handshake.
- On a velocity request, samples the plane's speed, pitch and heading, and resolves them into Cartesian velocity components v_x, v_y, v_z using a shared sine ROM and one shared multiplier.
- Returns the components with a one-cycle ready pulse.
- Sits between the plane state updater (which waits on ready) and nothing else; outputs are registered and held between requests.

---
 rtl/velocity_resolver.sv | 204 ++++++++++++++++++++
 tb/tb_velocity_resolver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/velocity_resolver.sv
// Velocity responder: resolves speed/pitch/heading into Cartesian Q16.16 components
// using one synchronous two-port sine ROM and a single shared 32x32 multiplier.
module velocity_resolver #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ROUND_ANGLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  request_velocities,
   output logic                  velocities_ready,
   output logic                  busy,
   input  logic [DATA_WIDTH-1:0] speed,
   input  logic [DATA_WIDTH-1:0] pitch,
   input  logic [DATA_WIDTH-1:0] heading,
   output logic [DATA_WIDTH-1:0] v_x,
   output logic [DATA_WIDTH-1:0] v_y,
   output logic [DATA_WIDTH-1:0] v_z
);

   typedef enum logic [2:0] {
      StIdle, StAddrP, StMulVy, StMulVh, StAddrH, StMulVx, StMulVz, StDone
   } state_e;

   state_e state_q, state_d;

   logic [DATA_WIDTH-1:0] speed_q;
   logic [8:0]            pitch_deg_q, heading_deg_q;
   logic [16:0]           sin_mag_q, cos_mag_q;
   logic                  sin_neg_q, cos_neg_q;
   logic [DATA_WIDTH-1:0] vy_q, vh_q, vx_q;
   logic [DATA_WIDTH-1:0] v_x_q, v_y_q, v_z_q;

   logic                  rom_en;
   logic [8:0]            rom_deg, cos_deg;
   logic [9:0]            sin_qd, cos_qd;
   logic [DATA_WIDTH-1:0] mul_a;
   logic [16:0]           mul_mag;
   logic                  mul_neg;
   logic [DATA_WIDTH-1:0] mul_res;

   // Q16.16 angle to integer degree in 0..359
   function automatic logic [8:0] quantise(input logic [31:0] a);
      logic signed [31:0] t;
      if (ROUND_ANGLES != 0) t = $signed(a + 32'h0000_8000) >>> 16;
      else                   t = $signed(a) >>> 16;
      if (t < 0)         t = t + 360;
      else if (t >= 360) t = t - 360;
      return t[8:0];
   endfunction

   // Fold 0..359 onto the 0..90 table; returns {negate, index}
   function automatic logic [9:0] quadrant(input logic [8:0] d);
      logic [9:0] r;
      if (d <= 9'd90)       r = {1'b0, d};
      else if (d <= 9'd180) r = {1'b0, 9'd180 - d};
      else if (d <= 9'd270) r = {1'b1, d - 9'd180};
      else                  r = {1'b1, 9'd360 - d};
      return r;
   endfunction

   function automatic logic [16:0] sin_lut(input logic [8:0] idx);
      logic [16:0] v;
      case (idx)
         9'd0: v = 17'd0;      9'd1: v = 17'd1144;   9'd2: v = 17'd2287;   9'd3: v = 17'd3430;
         9'd4: v = 17'd4572;   9'd5: v = 17'd5712;   9'd6: v = 17'd6850;   9'd7: v = 17'd7987;
         9'd8: v = 17'd9121;   9'd9: v = 17'd10252;  9'd10: v = 17'd11380; 9'd11: v = 17'd12505;
         9'd12: v = 17'd13626; 9'd13: v = 17'd14742; 9'd14: v = 17'd15855; 9'd15: v = 17'd16962;
         9'd16: v = 17'd18064; 9'd17: v = 17'd19161; 9'd18: v = 17'd20252; 9'd19: v = 17'd21336;
         9'd20: v = 17'd22415; 9'd21: v = 17'd23486; 9'd22: v = 17'd24550; 9'd23: v = 17'd25607;
         9'd24: v = 17'd26656; 9'd25: v = 17'd27697; 9'd26: v = 17'd28729; 9'd27: v = 17'd29753;
         9'd28: v = 17'd30767; 9'd29: v = 17'd31772; 9'd30: v = 17'd32768; 9'd31: v = 17'd33754;
         9'd32: v = 17'd34729; 9'd33: v = 17'd35693; 9'd34: v = 17'd36647; 9'd35: v = 17'd37590;
         9'd36: v = 17'd38521; 9'd37: v = 17'd39441; 9'd38: v = 17'd40348; 9'd39: v = 17'd41243;
         9'd40: v = 17'd42126; 9'd41: v = 17'd42995; 9'd42: v = 17'd43852; 9'd43: v = 17'd44695;
         9'd44: v = 17'd45525; 9'd45: v = 17'd46341; 9'd46: v = 17'd47143; 9'd47: v = 17'd47930;
         9'd48: v = 17'd48703; 9'd49: v = 17'd49461; 9'd50: v = 17'd50203; 9'd51: v = 17'd50931;
         9'd52: v = 17'd51643; 9'd53: v = 17'd52339; 9'd54: v = 17'd53020; 9'd55: v = 17'd53684;
         9'd56: v = 17'd54332; 9'd57: v = 17'd54963; 9'd58: v = 17'd55578; 9'd59: v = 17'd56175;
         9'd60: v = 17'd56756; 9'd61: v = 17'd57319; 9'd62: v = 17'd57865; 9'd63: v = 17'd58393;
         9'd64: v = 17'd58903; 9'd65: v = 17'd59396; 9'd66: v = 17'd59870; 9'd67: v = 17'd60326;
         9'd68: v = 17'd60764; 9'd69: v = 17'd61183; 9'd70: v = 17'd61584; 9'd71: v = 17'd61966;
         9'd72: v = 17'd62328; 9'd73: v = 17'd62672; 9'd74: v = 17'd62997; 9'd75: v = 17'd63303;
         9'd76: v = 17'd63589; 9'd77: v = 17'd63856; 9'd78: v = 17'd64104; 9'd79: v = 17'd64332;
         9'd80: v = 17'd64540; 9'd81: v = 17'd64729; 9'd82: v = 17'd64898; 9'd83: v = 17'd65048;
         9'd84: v = 17'd65177; 9'd85: v = 17'd65287; 9'd86: v = 17'd65376; 9'd87: v = 17'd65446;
         9'd88: v = 17'd65496; 9'd89: v = 17'd65526; 9'd90: v = 17'd65536;
         default: v = 17'd0;
      endcase
      return v;
   endfunction

   // Signed Q16.16 x unsigned table magnitude, sign applied to the full product
   function automatic logic [31:0] mul_q16(input logic [31:0] a, input logic [16:0] mag,
                                           input logic neg);
      logic signed [63:0] p;
      p = $signed({{32{a[31]}}, a}) * $signed({47'd0, mag});
      if (neg) p = -p;
      return p[47:16];
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (request_velocities) state_d = StAddrP;
         StAddrP: state_d = StMulVy;
         StMulVy: state_d = StMulVh;
         StMulVh: state_d = StAddrH;
         StAddrH: state_d = StMulVx;
         StMulVx: state_d = StMulVz;
         StMulVz: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign busy             = (state_q != StIdle);
   assign velocities_ready = (state_q == StDone);

   always_comb begin
      rom_en  = 1'b0;
      rom_deg = heading_deg_q;
      if (state_q == StAddrP) begin
         rom_en  = 1'b1;
         rom_deg = pitch_deg_q;
      end else if (state_q == StAddrH) begin
         rom_en  = 1'b1;
      end
      cos_deg = (rom_deg >= 9'd270) ? rom_deg - 9'd270 : rom_deg + 9'd90;
      sin_qd  = quadrant(rom_deg);
      cos_qd  = quadrant(cos_deg);
   end

   always_comb begin
      mul_a   = vh_q;
      mul_mag = sin_mag_q;
      mul_neg = sin_neg_q;
      case (state_q)
         StMulVy: mul_a = speed_q;
         StMulVh: begin
            mul_a   = speed_q;
            mul_mag = cos_mag_q;
            mul_neg = cos_neg_q;
         end
         StMulVz: begin
            mul_mag = cos_mag_q;
            mul_neg = ~cos_neg_q;
         end
         default: ;
      endcase
      mul_res = mul_q16(mul_a, mul_mag, mul_neg);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         speed_q       <= '0;
         pitch_deg_q   <= '0;
         heading_deg_q <= '0;
         sin_mag_q     <= '0;
         cos_mag_q     <= '0;
         sin_neg_q     <= 1'b0;
         cos_neg_q     <= 1'b0;
         vy_q          <= '0;
         vh_q          <= '0;
         vx_q          <= '0;
         v_x_q         <= '0;
         v_y_q         <= '0;
         v_z_q         <= '0;
      end else begin
         if (state_q == StIdle && request_velocities) begin
            speed_q       <= speed;
            pitch_deg_q   <= quantise(pitch);
            heading_deg_q <= quantise(heading);
         end
         if (rom_en) begin
            sin_neg_q <= sin_qd[9];
            sin_mag_q <= sin_lut(sin_qd[8:0]);
            cos_neg_q <= cos_qd[9];
            cos_mag_q <= sin_lut(cos_qd[8:0]);
         end
         // All three outputs commit together on the edge entering StDone
         case (state_q)
            StMulVy: vy_q <= mul_res;
            StMulVh: vh_q <= mul_res;
            StMulVx: vx_q <= mul_res;
            StMulVz: begin
               v_x_q <= vx_q;
               v_y_q <= vy_q;
               v_z_q <= mul_res;
            end
            default: ;
         endcase
      end
   end

   assign v_x = v_x_q;
   assign v_y = v_y_q;
   assign v_z = v_z_q;

endmodule

// File: tb/tb_velocity_resolver.sv
// Directed and randomized bench for velocity_resolver against a real-valued trig model.
module tb_velocity_resolver;

   logic        clk = 1'b0;
   logic        reset;
   logic        request_velocities;
   logic        velocities_ready;
   logic        busy;
   logic [31:0] speed, pitch, heading;
   logic [31:0] v_x, v_y, v_z;

   int total = 0;
   int bad   = 0;
   logic [31:0] prev_x, prev_y, prev_z;

   localparam real Pi = 3.14159265358979323846;

   always #5 clk = ~clk;

   velocity_resolver dut (
      .clk                (clk),
      .reset              (reset),
      .request_velocities (request_velocities),
      .velocities_ready   (velocities_ready),
      .busy               (busy),
      .speed              (speed),
      .pitch              (pitch),
      .heading            (heading),
      .v_x                (v_x),
      .v_y                (v_y),
      .v_z                (v_z)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Nearest whole degree, folded into 0..359
   function automatic int qdeg(input logic [31:0] a);
      real r;
      int  t;
      r = $itor($signed(a)) / 65536.0;
      t = $rtoi($floor(r + 0.5));
      return ((t % 360) + 360) % 360;
   endfunction

   function automatic longint sinq(input int d);
      real    s;
      longint m;
      s = $sin(d * Pi / 180.0);
      m = longint'($rtoi(((s < 0.0) ? -s : s) * 65536.0 + 0.5));
      return (s < 0.0) ? -m : m;
   endfunction

   function automatic logic [31:0] fx(input longint a, input longint b);
      logic signed [63:0] p;
      p = a * b;
      return p[47:16];
   endfunction

   task automatic model(input logic [31:0] s, input logic [31:0] p, input logic [31:0] h,
                        output logic [31:0] ex, output logic [31:0] ey, output logic [31:0] ez);
      int     dp, dh;
      longint sp, horiz;
      dp    = qdeg(p);
      dh    = qdeg(h);
      sp    = longint'({32'd0, s});
      ey    = fx(sp, sinq(dp));
      horiz = longint'($signed(fx(sp, sinq((dp + 90) % 360))));
      ex    = fx(horiz, sinq(dh));
      ez    = fx(horiz, -sinq((dh + 90) % 360));
   endtask

   function automatic logic [31:0] rand_angle();
      int ip;
      ip = int'($urandom_range(1077, 0)) - 359;
      return 32'(ip * 65536) + $urandom_range(65535, 0);
   endfunction

   task automatic chk_out(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                          input logic [31:0] ez);
      chk({tag, "_vx"}, v_x, ex);
      chk({tag, "_vy"}, v_y, ey);
      chk({tag, "_vz"}, v_z, ez);
   endtask

   // One request; checks busy/ready on every cycle, outputs held until commit
   task automatic run_req(input logic [31:0] s, input logic [31:0] p, input logic [31:0] h,
                          input string tag);
      logic [31:0] ex, ey, ez;
      model(s, p, h, ex, ey, ez);
      @(negedge clk);
      speed = s; pitch = p; heading = h; request_velocities = 1'b1;
      @(negedge clk);
      request_velocities = 1'b0;
      speed = $urandom; pitch = $urandom; heading = $urandom;
      for (int k = 1; k <= 7; k++) begin
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_ready"}, {31'd0, velocities_ready}, (k == 7) ? 32'd1 : 32'd0);
         if (k < 7) chk_out({tag, "_hold"}, prev_x, prev_y, prev_z);
         else       chk_out(tag, ex, ey, ez);
         @(negedge clk);
      end
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_idle_ready"}, {31'd0, velocities_ready}, 32'd0);
      chk_out({tag, "_kept"}, ex, ey, ez);
      prev_x = ex; prev_y = ey; prev_z = ez;
   endtask

   initial begin
      logic [31:0] ax, ay, az, sv_z;
      reset = 1'b1; request_velocities = 1'b0;
      speed = '0; pitch = '0; heading = '0;
      prev_x = '0; prev_y = '0; prev_z = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, velocities_ready}, 32'd0);
      chk_out("rst", 32'd0, 32'd0, 32'd0);

      run_req(32'h0014_0000, 32'h0, 32'h0, "level_north");
      chk("level_north_lit_vz", v_z, 32'hFFEC_0000);
      chk("level_north_lit_vx", v_x, 32'h0);

      run_req(32'h0014_0000, 32'h0, 32'h005A_0000, "level_east");
      chk("level_east_lit_vx", v_x, 32'h0014_0000);
      chk("level_east_lit_vz", v_z, 32'h0);

      run_req(32'h0014_0000, 32'h001E_0000, 32'h0, "climb30");
      chk("climb30_lit_vy", v_y, 32'h000A_0000);
      sv_z = v_z;
      run_req(32'h0014_0000, 32'hFFE2_0000, 32'h0, "dive30");
      chk("dive30_lit_vy", v_y, 32'hFFF6_0000);
      chk("dive30_same_vz", v_z, sv_z);

      run_req(32'h0014_0000, 32'h0, 32'h0167_999A, "hdg_wrap");
      chk("hdg_wrap_lit_vz", v_z, 32'hFFEC_0000);
      chk("hdg_wrap_lit_vx", v_x, 32'h0);
      run_req(32'h0014_0000, 32'h005A_0000, 32'h0, "vertical");
      chk("vertical_lit_vy", v_y, 32'h0014_0000);
      chk("vertical_lit_vx", v_x, 32'h0);
      chk("vertical_lit_vz", v_z, 32'h0);

      // Requests during busy and during the ready cycle are dropped
      model(32'h0020_0000, 32'h000A_0000, 32'h002D_0000, ax, ay, az);
      @(negedge clk);
      speed = 32'h0020_0000; pitch = 32'h000A_0000; heading = 32'h002D_0000;
      request_velocities = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 7; k++) begin
         request_velocities = (k == 3 || k == 7);
         if (k == 3) begin
            speed = 32'h0005_0000; pitch = 32'hFFB0_0000; heading = 32'h0100_0000;
         end
         chk("ignore_ready", {31'd0, velocities_ready}, (k == 7) ? 32'd1 : 32'd0);
         if (k == 7) chk_out("ignore", ax, ay, az);
         @(negedge clk);
      end
      request_velocities = 1'b0;
      for (int j = 0; j < 10; j++) begin
         chk("ignore_no_pulse", {31'd0, velocities_ready}, 32'd0);
         chk("ignore_no_busy", {31'd0, busy}, 32'd0);
         @(negedge clk);
      end
      chk_out("ignore_kept", ax, ay, az);
      prev_x = ax; prev_y = ay; prev_z = az;

      // Reset while in the heading-multiply phase
      speed = 32'h0030_0000; pitch = 32'h0014_0000; heading = 32'h0050_0000;
      request_velocities = 1'b1;
      @(negedge clk);
      request_velocities = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_out("abort", 32'd0, 32'd0, 32'd0);
      chk("abort_ready", {31'd0, velocities_ready}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      prev_x = '0; prev_y = '0; prev_z = '0;
      run_req(32'h0030_0000, 32'h0014_0000, 32'h0050_0000, "after_abort");

      for (int i = 0; i < 40; i++) begin
         run_req($urandom & 32'h00FF_FFFF, rand_angle(), rand_angle(), "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
